// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types, widths and helpers for the multiply unit
package mul_pkg;

  localparam int OP_W   = 16;
  localparam int PROD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // Magnitude of a 16-bit operand; 0x8000 in signed mode maps to 32768.
  function automatic logic [OP_W-1:0] abs16(input logic [OP_W-1:0] x, input logic signed_mode);
    if (signed_mode && x[OP_W-1]) begin
      return ~x + 16'd1;
    end
    return x;
  endfunction

endpackage

// File: rtl/mul.sv
// rtl/mul.sv - combinational 16x16 unsigned array multiplier
module mul (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] mulo
);

  // Accumulate one shifted partial product per multiplier bit
  always_comb begin
    mulo = 32'd0;
    for (int i = 0; i < 16; i++) begin
      if (b[i]) begin
        mulo = mulo + ({16'd0, a} << i);
      end
    end
  end

endmodule

// File: rtl/mul_unit.sv
// rtl/mul_unit.sv - sequential signed/unsigned multiply wrapper with overflow tracking
module mul_unit
  import mul_pkg::*;
#(
  parameter int LAT   = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [15:0]      op_a,
  input  logic [15:0]      op_b,
  input  logic             op_signed,
  input  logic             op_hi,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_data,
  output logic             res_ovf,
  output logic [CNT_W-1:0] ovf_count
);

  mul_state_t        state;
  mul_state_t        state_nxt;
  logic [2:0]        cnt;
  logic [OP_W-1:0]   mag_a;
  logic [OP_W-1:0]   mag_b;
  logic              neg;
  logic              sgn;
  logic              hi;
  logic [PROD_W-1:0] mulo;
  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] prod_nxt;
  logic              ovf;
  logic              ovf_nxt;
  logic              accept;
  logic              capture;
  logic              retire;

  // The array sees only registered magnitudes, so it has LAT cycles to settle
  mul u_mul (
    .a    (mag_a),
    .b    (mag_b),
    .mulo (mulo)
  );

  // Reapply the sign and judge whether the full product fits in 16 bits
  always_comb begin
    prod_nxt = neg ? (~mulo + 32'd1) : mulo;
    if (sgn) begin
      ovf_nxt = !((&prod_nxt[31:15]) || !(|prod_nxt[31:15]));
    end else begin
      ovf_nxt = |prod_nxt[31:16];
    end
  end

  // Next state and handshake outputs; flush overrides every transition
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    res_valid = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    retire    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = rst_n;
        if (rst_n && req_valid) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt == 3'd0) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          retire    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt = IDLE;
      accept    = 1'b0;
      capture   = 1'b0;
      retire    = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand latch, multicycle countdown, product capture and overflow counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= 3'd0;
      mag_a     <= '0;
      mag_b     <= '0;
      neg       <= 1'b0;
      sgn       <= 1'b0;
      hi        <= 1'b0;
      prod      <= '0;
      ovf       <= 1'b0;
      ovf_count <= '0;
    end else begin
      if (accept) begin
        mag_a <= abs16(op_a, op_signed);
        mag_b <= abs16(op_b, op_signed);
        neg   <= op_signed & (op_a[15] ^ op_b[15]);
        sgn   <= op_signed;
        hi    <= op_hi;
        cnt   <= 3'(LAT - 1);
      end else if (state == BUSY && cnt != 3'd0) begin
        cnt <= cnt - 3'd1;
      end
      if (capture) begin
        prod <= prod_nxt;
        ovf  <= ovf_nxt;
      end
      if (retire && ovf && (ovf_count != {CNT_W{1'b1}})) begin
        ovf_count <= ovf_count + CNT_W'(1);
      end
    end
  end

  assign res_data = hi ? prod[31:16] : prod[15:0];
  assign res_ovf  = ovf;

endmodule

// File: tb/tb_mul_unit.sv
// tb/tb_mul_unit.sv - directed self-checking bench for mul_unit
module tb_mul_unit;

  localparam int LAT   = 2;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             req_valid;
  logic             req_ready;
  logic [15:0]      op_a;
  logic [15:0]      op_b;
  logic             op_signed;
  logic             op_hi;
  logic             res_valid;
  logic             res_ready;
  logic [15:0]      res_data;
  logic             res_ovf;
  logic [CNT_W-1:0] ovf_count;

  int n_pass  = 0;
  int n_total = 0;

  mul_unit #(.LAT(LAT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_signed (op_signed),
    .op_hi     (op_hi),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_ovf   (res_ovf),
    .ovf_count (ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // issue one request, wait for the result, then retire it
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s, input logic h,
                        output logic [15:0] d, output logic v, output int lat);
    op_a      = a;
    op_b      = b;
    op_signed = s;
    op_hi     = h;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 20) begin
      tick();
      lat++;
    end
    if (!res_valid) lat = -1;
    d = res_data;
    v = res_ovf;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  // one directed vector with all its expectations
  task automatic vec(input string tag, input logic [15:0] a, input logic [15:0] b, input logic s,
                     input logic h, input logic [15:0] exp_d, input logic exp_v, input int exp_cnt);
    logic [15:0] d;
    logic        v;
    int          lat;
    run_op(a, b, s, h, d, v, lat);
    chk({tag, "_lat"}, lat, LAT);
    chk({tag, "_data"}, d, exp_d);
    chk({tag, "_ovf"}, v, exp_v);
    chk({tag, "_cnt"}, ovf_count, exp_cnt);
  endtask

  initial begin
    logic [15:0] d;
    logic        v;
    int          lat;
    int          bad;
    int          seen;

    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; res_ready = 1'b0;
    op_a = 16'd0; op_b = 16'd0; op_signed = 1'b0; op_hi = 1'b0;
    tick();
    tick();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_ovf", res_ovf, 0);
    chk("rst_ovf_count", ovf_count, 0);
    rst_n = 1'b1;
    #1;
    chk("idle_req_ready", req_ready, 1);

    vec("u300x200",   16'd300,  16'd200,  1'b0, 1'b0, 16'hEA60, 1'b0, 0);
    vec("u100sq_lo",  16'h0100, 16'h0100, 1'b0, 1'b0, 16'h0000, 1'b1, 1);
    vec("u100sq_hi",  16'h0100, 16'h0100, 1'b0, 1'b1, 16'h0001, 1'b1, 2);
    vec("sm3x7_lo",   16'hFFFD, 16'h0007, 1'b1, 1'b0, 16'hFFEB, 1'b0, 2);
    vec("sm3x7_hi",   16'hFFFD, 16'h0007, 1'b1, 1'b1, 16'hFFFF, 1'b0, 2);
    vec("s8000sq_lo", 16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0000, 1'b1, 3);
    vec("s8000sq_hi", 16'h8000, 16'h8000, 1'b1, 1'b1, 16'h4000, 1'b1, 4);
    vec("s_min_fit",  16'h8000, 16'h0001, 1'b1, 1'b0, 16'h8000, 1'b0, 4);
    vec("s_min_neg",  16'hFFFF, 16'h8000, 1'b1, 1'b0, 16'h8000, 1'b1, 5);
    vec("s_zero",     16'h0000, 16'hFFFF, 1'b1, 1'b1, 16'h0000, 1'b0, 5);
    vec("u_max_fit",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'hFFFF, 1'b0, 5);

    // backpressure: result held for 5 cycles
    op_a = 16'h00FF; op_b = 16'h00FF; op_signed = 1'b0; op_hi = 1'b0;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("busy_req_ready", req_ready, 0);
    seen = 0;
    while (!res_valid && seen < 20) begin
      tick();
      seen++;
    end
    chk("bp_lat", seen, LAT);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (res_valid !== 1'b1 || res_data !== 16'hFE01 || res_ovf !== 1'b0 || req_ready !== 1'b0) bad++;
      tick();
    end
    chk("bp_stable", bad, 0);
    chk("bp_still_valid", res_valid, 1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("bp_ret_valid", res_valid, 0);
    chk("bp_ret_ready", req_ready, 1);

    // preload the overflow counter from reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("re_rst_cnt", ovf_count, 0);
    bad = 0;
    for (int i = 0; i < 255; i++) begin
      run_op(16'h0100, 16'h0100, 1'b0, i[0], d, v, lat);
      if (lat != LAT || v !== 1'b1) bad++;
    end
    chk("preload_ops", bad, 0);
    chk("preload_cnt", ovf_count, 255);
    vec("sat", 16'h0200, 16'h0300, 1'b0, 1'b1, 16'h0006, 1'b1, 255);

    // flush during BUSY
    op_a = 16'h1234; op_b = 16'h5678; op_signed = 1'b0; op_hi = 1'b0;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_idle", req_ready, 1);
    seen = 0;
    for (int i = 0; i < LAT + 3; i++) begin
      if (res_valid) seen++;
      tick();
    end
    chk("flush_no_valid", seen, 0);

    // request coincident with flush is dropped
    req_valid = 1'b1;
    flush = 1'b1;
    tick();
    req_valid = 1'b0;
    flush = 1'b0;
    chk("flush_req_drop", req_ready, 1);
    seen = 0;
    for (int i = 0; i < LAT + 3; i++) begin
      if (res_valid) seen++;
      tick();
    end
    chk("flush_req_no_valid", seen, 0);
    chk("flush_cnt_kept", ovf_count, 255);

    // reset while a result waits in DONE
    op_a = 16'h0300; op_b = 16'h0100; op_signed = 1'b0; op_hi = 1'b1;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    seen = 0;
    while (!res_valid && seen < 20) begin
      tick();
      seen++;
    end
    chk("pre_rst_valid", res_valid, 1);
    chk("pre_rst_data", res_data, 16'h0003);
    rst_n = 1'b0;
    tick();
    chk("done_rst_valid", res_valid, 0);
    chk("done_rst_data", res_data, 0);
    chk("done_rst_ovf", res_ovf, 0);
    chk("done_rst_cnt", ovf_count, 0);
    chk("done_rst_ready", req_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", req_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
